disp_colr_adapt: RTL
====================

# disp_colr_adapt

Parametrised display colour adapter between a chapter core's display outputs and the board's TMDS encoder. It replaces ad-hoc per-board colour widening with a registered stage that converts any input depth to any output depth across a configurable channel count. Widening uses bit replication; narrowing uses truncation or, optionally, 4x4 ordered dithering. Sync and data-enable are delayed to stay aligned with colour, and colour is forced to zero outside the active area.

## Interface
- `CHAN`, 3: colour channel count; channel 0 occupies the LSBs of the colour buses.
- `BPC_IN`, 5: input bits per channel (1–16).
- `BPC_OUT`, 8: output bits per channel (1–16).
- `SYNC_ACT`, 1: active level of `in_vsync`, used by the dither line counter.
- `clk`  in  1: pixel clock.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `in_hsync`  in  1: horizontal sync.
- `in_vsync`  in  1: vertical sync.
- `in_de`  in  1: data enable.
- `in_colr`  in  CHAN*BPC_IN: pixel colour.
- `out_hsync`  out  1: `in_hsync` delayed by 2 cycles.
- `out_vsync`  out  1: `in_vsync` delayed by 2 cycles.
- `out_de`  out  1: `in_de` delayed by 2 cycles.
- `out_colr`  out  CHAN*BPC_OUT: converted colour; zero when `out_de` is 0.

## Operation
- Mode is chosen per elaboration:
  - `BPC_OUT == BPC_IN`: pass-through.
  - `BPC_OUT > BPC_IN`: widen.
  - `BPC_OUT < BPC_IN`: narrow.
- Widen: repeat the input bits MSB-first until `BPC_OUT` bits are filled, then truncate. Example: 5→8 maps `abcde` to `abcdeabc`. 0 maps to 0; all-ones maps to all-ones.
- Narrow: let D = `BPC_IN` − `BPC_OUT`, base = in >> D, low = in[D-1:0].
  - Without dither: out = base.
  - With dither:
    - Bayer matrix B[y][x] by rows: {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
    - Threshold = B >> (4−D) if D ≤ 4, otherwise B << (D−4).
    - out = base + 1 when low > threshold and base is not all-ones; otherwise out = base. The result saturates and never wraps.
- Position counters (2 bits each, wrap mod 4):
  - x: cleared on the cycle `in_de` rises; increments on each cycle `in_de` is high.
  - y: increments on each `in_de` falling edge; cleared when `in_vsync` enters `SYNC_ACT`.
  - If the x clear and the y increment occur on the same cycle, both take effect.
- All channels of a pixel use the same threshold.
- Blanking: when the delayed DE is 0, `out_colr` is 0 regardless of input.

## Timing
- Latency is exactly 2 cycles for every output, in every mode.
  - Stage 1 registers the inputs and the threshold.
  - Stage 2 registers the converted colour and the delayed syncs and DE.
- Throughput: one pixel per clock; there is no backpressure.
- Reset (asynchronous assert, synchronous-safe release):
  - All outputs go to 0 immediately: syncs, DE and colour.
  - Pipeline stages and x/y counters clear.
- Reset mid-line: after release, the first two output cycles are 0. The next `in_de` rise starts x at 0; y is 0 until the first DE fall.
- Narrow-mode counters ignore `in_hsync`; positions derive from DE only.

## Configuration
- Macro `DISP_COLR_DITHER_EN`.
- Defined: narrowing uses the ordered dither above.
- Undefined:
  - Narrowing truncates.
  - Position counters and the threshold logic are not built.
  - Latency remains 2 cycles.
- Widen and pass-through modes are unaffected by the macro.

## Structure
- Shared package `disp_pkg` holds:
  - the Bayer 4x4 constant;
  - a constant function for the replication widen;
  - a constant function for the threshold shift.
- One natural sub-module, `colr_chan_conv`: converts a single channel, one instance per channel via generate. It takes `BPC_IN`, `BPC_OUT`, colour and threshold, and its output is registered in stage 2 by the parent.

## Test plan
- Widen, CHAN=3, 5→8:
  - Channel inputs 5'h16, 5'h1F, 5'h00 with DE=1 → 8'hB5, 8'hFF, 8'h00 two cycles later.
  - Syncs and DE shifted by 2 cycles.
- Narrow 8→5, macro off: input 8'hB7 on all channels → 5'h16; input 8'hFF → 5'h1F.
- Narrow 8→5, macro on: constant 8'h84 over a 4x4 block (4 lines × 4 DE pixels) → exactly 8 pixels at 5'h11 and 8 at 5'h10. Pixel (0,0) is 5'h11; pixel (2,2) is 5'h11.
- Saturation, macro on: 8'hFF at every position → 5'h1F always. Input 8'h07 at (0,0) → 5'h01; at row 3, col 0 (threshold 7) → 5'h00.
- Blanking: DE=0 with input 8'hFF → `out_colr` = 0 while `out_hsync`/`out_vsync` still track the inputs delayed by 2 cycles.
- Reset: assert `rst_n`=0 mid-line → all outputs 0 in the same cycle. After release, x restarts at the next DE rise and the first pixel uses threshold B[0][0].

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and helpers for the display colour adapter.
package disp_pkg;

   localparam logic [3:0] BAYER [4][4] = '{
      '{4'd0,  4'd8,  4'd2,  4'd10},
      '{4'd12, 4'd4,  4'd14, 4'd6},
      '{4'd3,  4'd11, 4'd1,  4'd9},
      '{4'd15, 4'd7,  4'd13, 4'd5}
   };

   // MSB-first bit replication of a bin-bit value into bout bits (result in the LSBs)
   function automatic logic [15:0] widen(input logic [15:0] v, input int bin, input int bout);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < bout; i++) r[4'(bout-1-i)] = v[4'(bin-1-(i%bin))];
      return r;
   endfunction

   function automatic logic [15:0] thr_shift(input logic [3:0] b, input int d);
      return d <= 4 ? 16'(b) >> (4-d) : 16'(b) << (d-4);
   endfunction

endpackage

// File: rtl/colr_chan_conv.sv
// colr_chan_conv: combinational depth conversion of one colour channel.
// Narrowing uses ordered dither when DISP_COLR_DITHER_EN is defined, else truncation.
module colr_chan_conv
   import disp_pkg::*;
#(
   parameter int BPC_IN  = 5,
   parameter int BPC_OUT = 8
)(
   input  logic [BPC_IN-1:0]  colr,
   input  logic [15:0]        thr,
   output logic [BPC_OUT-1:0] conv
);

   logic unused_thr;
   assign unused_thr = ^thr;

   if (BPC_OUT == BPC_IN) begin : g_pass
      assign conv = colr;
   end else if (BPC_OUT > BPC_IN) begin : g_wide
      assign conv = BPC_OUT'(widen(16'(colr), BPC_IN, BPC_OUT));
   end else begin : g_narrow
      localparam int D = BPC_IN - BPC_OUT;
      logic [BPC_OUT-1:0] base;
      assign base = colr[BPC_IN-1:D];
`ifdef DISP_COLR_DITHER_EN
      // round up only below full scale so the result saturates instead of wrapping
      assign conv = (16'(colr[D-1:0]) > thr && base != '1) ? base + BPC_OUT'(1) : base;
`else
      logic [D-1:0] unused_low;
      assign unused_low = colr[D-1:0];
      assign conv = base;
`endif
   end

endmodule

// File: rtl/disp_colr_adapt.sv
// disp_colr_adapt: two-stage colour depth adapter with aligned sync/DE and blanking.
// Define DISP_COLR_DITHER_EN for 4x4 ordered dither when narrowing.
module disp_colr_adapt
   import disp_pkg::*;
#(
   parameter int   CHAN     = 3,
   parameter int   BPC_IN   = 5,
   parameter int   BPC_OUT  = 8,
   parameter logic SYNC_ACT = 1'b1
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_hsync,
   input  logic                      in_vsync,
   input  logic                      in_de,
   input  logic [CHAN*BPC_IN-1:0]    in_colr,
   output logic                      out_hsync,
   output logic                      out_vsync,
   output logic                      out_de,
   output logic [CHAN*BPC_OUT-1:0]   out_colr
);

   logic                    s1_hs;
   logic                    s1_vs;
   logic                    s1_de;
   logic [CHAN*BPC_IN-1:0]  s1_colr;
   logic [15:0]             s1_thr;
   logic [CHAN*BPC_OUT-1:0] conv;

`ifdef DISP_COLR_DITHER_EN
   logic [1:0] x;
   logic [1:0] y;
   logic [1:0] x_pix;
   logic       de_rise;
   logic       de_fall;
   logic       vs_enter;

   // stage-1 registers double as the previous-cycle history for edge detection
   always_comb begin
      de_rise  = in_de & ~s1_de;
      de_fall  = ~in_de & s1_de;
      vs_enter = (in_vsync == SYNC_ACT) && (s1_vs != SYNC_ACT);
      x_pix    = de_rise ? 2'd0 : x;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x      <= '0;
         y      <= '0;
         s1_thr <= '0;
      end else begin
         x      <= in_de ? x_pix + 2'd1 : x;
         y      <= vs_enter ? 2'd0 : de_fall ? y + 2'd1 : y;
         s1_thr <= thr_shift(BAYER[y][x_pix], BPC_IN > BPC_OUT ? BPC_IN - BPC_OUT : 4);
      end
   end
`else
   assign s1_thr = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {s1_hs, s1_vs, s1_de}          <= '0;
         s1_colr                        <= '0;
         {out_hsync, out_vsync, out_de} <= '0;
         out_colr                       <= '0;
      end else begin
         {s1_hs, s1_vs, s1_de}          <= {in_hsync, in_vsync, in_de};
         s1_colr                        <= in_colr;
         {out_hsync, out_vsync, out_de} <= {s1_hs, s1_vs, s1_de};
         out_colr                       <= s1_de ? conv : '0;
      end
   end

   for (genvar c = 0; c < CHAN; c++) begin : g_chan
      colr_chan_conv #(
         .BPC_IN  (BPC_IN),
         .BPC_OUT (BPC_OUT)
      ) u_conv (
         .colr (s1_colr[c*BPC_IN +: BPC_IN]),
         .thr  (s1_thr),
         .conv (conv[c*BPC_OUT +: BPC_OUT])
      );
   end

endmodule
